// File: rtl/mem_wb_stage.sv
// M-stage data-memory access plus the M->W pipeline register.
// Also drives the combinational M-stage forwarding tap used by the hazard unit.
module mem_wb_stage #(
    parameter int DM_AW = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir_m,
    input  logic [31:0] aluout_m,
    input  logic [31:0] rt_m,
    input  logic [31:0] pc8_m,
    input  logic        bgezal_m,
    input  logic        movz_m,
    output logic [4:0]  fwd_m_addr,
    output logic [31:0] fwd_m_data,
    output logic [31:0] ir_w,
    output logic        rf_we_w,
    output logic [4:0]  rf_waddr_w,
    output logic [31:0] rf_wdata_w
);

    localparam int DM_DEPTH = 1 << DM_AW;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_ADDIU  = 6'b001001;
    localparam logic [5:0] OP_SLTI   = 6'b001010;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_LUI    = 6'b001111;
    localparam logic [5:0] OP_LB     = 6'b100000;
    localparam logic [5:0] OP_LH     = 6'b100001;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_LBU    = 6'b100100;
    localparam logic [5:0] OP_LHU    = 6'b100101;
    localparam logic [5:0] OP_SB     = 6'b101000;
    localparam logic [5:0] OP_SH     = 6'b101001;
    localparam logic [5:0] OP_SW     = 6'b101011;

    logic [5:0]  op;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic        wr_en;
    logic        is_link;
    logic        is_load;
    logic [4:0]  dest;
    logic [DM_AW-1:0] dm_idx;
    logic [31:0] dm_word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] wb_data;
    logic        rf_we_next;

    logic [31:0] dm [DM_DEPTH];

    assign op     = ir_m[31:26];
    assign rt     = ir_m[20:16];
    assign rd     = ir_m[15:11];
    assign funct  = ir_m[5:0];
    assign dm_idx = aluout_m[DM_AW+1:2];

    // rs/shamt and the address bits above the DM are not needed here
    logic unused_bits;
    assign unused_bits = ^{ir_m[25:21], ir_m[10:6], aluout_m[31:DM_AW+2]};

    always_comb begin
        wr_en   = 1'b0;
        is_link = 1'b0;
        is_load = 1'b0;
        dest    = 5'd0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    6'b100001, 6'b100011, 6'b100100,
                    6'b100101, 6'b101010, 6'b000000: begin
                        wr_en = 1'b1;
                        dest  = rd;
                    end
                    6'b001010: begin
                        wr_en = movz_m;
                        dest  = rd;
                    end
                    6'b001001: begin
                        wr_en   = 1'b1;
                        dest    = rd;
                        is_link = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_REGIMM: begin
                if (rt == 5'b10001) begin
                    wr_en   = bgezal_m;
                    dest    = 5'd31;
                    is_link = 1'b1;
                end
            end
            OP_JAL: begin
                wr_en   = 1'b1;
                dest    = 5'd31;
                is_link = 1'b1;
            end
            OP_ORI, OP_LUI, OP_ADDIU, OP_SLTI: begin
                wr_en = 1'b1;
                dest  = rt;
            end
            OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU: begin
                wr_en   = 1'b1;
                dest    = rt;
                is_load = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        dm_word  = dm[dm_idx];
        half_sel = aluout_m[1] ? dm_word[31:16] : dm_word[15:0];
        case (aluout_m[1:0])
            2'd0:    byte_sel = dm_word[7:0];
            2'd1:    byte_sel = dm_word[15:8];
            2'd2:    byte_sel = dm_word[23:16];
            default: byte_sel = dm_word[31:24];
        endcase
        case (op)
            OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_data = {24'd0, byte_sel};
            OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_data = {16'd0, half_sel};
            default: load_data = dm_word;
        endcase
    end

    assign wb_data    = is_load ? load_data : (is_link ? pc8_m : aluout_m);
    assign rf_we_next = wr_en && (dest != 5'd0);

    assign fwd_m_addr = (rf_we_next && !is_load) ? dest : 5'd0;
    assign fwd_m_data = is_link ? pc8_m : aluout_m;

    // Whole-array clear in one reset cycle, so DM is a flop array rather than a RAM macro
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DM_DEPTH; i++) begin
                dm[i] <= 32'd0;
            end
        end else begin
            case (op)
                OP_SW: dm[dm_idx] <= rt_m;
                OP_SH: begin
                    if (aluout_m[1]) dm[dm_idx][31:16] <= rt_m[15:0];
                    else             dm[dm_idx][15:0]  <= rt_m[15:0];
                end
                OP_SB: begin
                    case (aluout_m[1:0])
                        2'd0:    dm[dm_idx][7:0]   <= rt_m[7:0];
                        2'd1:    dm[dm_idx][15:8]  <= rt_m[7:0];
                        2'd2:    dm[dm_idx][23:16] <= rt_m[7:0];
                        default: dm[dm_idx][31:24] <= rt_m[7:0];
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ir_w       <= 32'd0;
            rf_we_w    <= 1'b0;
            rf_waddr_w <= 5'd0;
            rf_wdata_w <= 32'd0;
        end else begin
            ir_w       <= ir_m;
            rf_we_w    <= rf_we_next;
            rf_waddr_w <= rf_we_next ? dest : 5'd0;
            rf_wdata_w <= rf_we_next ? wb_data : 32'd0;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed-vector bench for mem_wb_stage with hand-computed expectations.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ir_m, aluout_m, rt_m, pc8_m;
    logic        bgezal_m, movz_m;
    logic [4:0]  fwd_m_addr;
    logic [31:0] fwd_m_data;
    logic [31:0] ir_w;
    logic        rf_we_w;
    logic [4:0]  rf_waddr_w;
    logic [31:0] rf_wdata_w;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.DM_AW(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .ir_m       (ir_m),
        .aluout_m   (aluout_m),
        .rt_m       (rt_m),
        .pc8_m      (pc8_m),
        .bgezal_m   (bgezal_m),
        .movz_m     (movz_m),
        .fwd_m_addr (fwd_m_addr),
        .fwd_m_data (fwd_m_data),
        .ir_w       (ir_w),
        .rf_we_w    (rf_we_w),
        .rf_waddr_w (rf_waddr_w),
        .rf_wdata_w (rf_wdata_w)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt);
        return {op, 5'd0, rt, 16'd0};
    endfunction

    function automatic logic [31:0] rtype(input logic [5:0] funct, input logic [4:0] rd);
        return {6'd0, 5'd0, 5'd0, rd, 5'd0, funct};
    endfunction

    // Present one M-stage instruction, settle, then clock it into W.
    task automatic drive(input logic [31:0] ir, input logic [31:0] alu, input logic [31:0] rtv,
                         input logic [31:0] pc8, input logic bg, input logic mz);
        ir_m = ir; aluout_m = alu; rt_m = rtv; pc8_m = pc8; bgezal_m = bg; movz_m = mz;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [31:0] ir, input logic [31:0] alu, input logic [31:0] rtv);
        drive(ir, alu, rtv, 32'd0, 1'b0, 1'b0);
        tick();
    endtask

    localparam logic [5:0] LW = 6'b100011, LB = 6'b100000, LBU = 6'b100100;
    localparam logic [5:0] LH = 6'b100001, LHU = 6'b100101;
    localparam logic [5:0] SW = 6'b101011, SH = 6'b101001, SB = 6'b101000;

    initial begin
        reset = 1'b1;
        drive(32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        tick();
        check("rst_ir_w", ir_w, 32'd0);
        check("rst_we", {31'd0, rf_we_w}, 32'd0);
        check("rst_waddr", {27'd0, rf_waddr_w}, 32'd0);
        check("rst_wdata", rf_wdata_w, 32'd0);
        reset = 1'b0;

        step(itype(LW, 5'd8), 32'h0000, 32'd0);
        check("lw0_we", {31'd0, rf_we_w}, 32'd1);
        check("lw0_waddr", {27'd0, rf_waddr_w}, 32'd8);
        check("lw0_data", rf_wdata_w, 32'd0);
        check("lw0_ir_w", ir_w, itype(LW, 5'd8));

        step(itype(SW, 5'd1), 32'h0010, 32'h12345678);
        check("sw_we", {31'd0, rf_we_w}, 32'd0);
        step(itype(LB, 5'd9), 32'h0013, 32'd0);
        check("lb13", rf_wdata_w, 32'h00000012);
        step(itype(LH, 5'd9), 32'h0012, 32'd0);
        check("lh12", rf_wdata_w, 32'h00001234);
        step(itype(LBU, 5'd9), 32'h0010, 32'd0);
        check("lbu10", rf_wdata_w, 32'h00000078);

        step(itype(SB, 5'd1), 32'h0021, 32'hFFFFFF80);
        step(itype(LB, 5'd10), 32'h0021, 32'd0);
        check("lb21", rf_wdata_w, 32'hFFFFFF80);
        step(itype(LBU, 5'd10), 32'h0021, 32'd0);
        check("lbu21", rf_wdata_w, 32'h00000080);
        step(itype(LW, 5'd10), 32'h0020, 32'd0);
        check("lw20_sb", rf_wdata_w, 32'h00008000);

        step(itype(SW, 5'd1), 32'h0030, 32'hAAAAAAAA);
        step(itype(SH, 5'd1), 32'h0032, 32'h1234BEEF);
        step(itype(LW, 5'd11), 32'h0030, 32'd0);
        check("lw30_sh", rf_wdata_w, 32'hBEEFAAAA);
        step(itype(LHU, 5'd11), 32'h0032, 32'd0);
        check("lhu32", rf_wdata_w, 32'h0000BEEF);
        step(itype(LH, 5'd11), 32'h0032, 32'd0);
        check("lh32", rf_wdata_w, 32'hFFFFBEEF);
        step(itype(LH, 5'd11), 32'h0030, 32'd0);
        check("lh30", rf_wdata_w, 32'hFFFFAAAA);

        // loads never forward from M
        drive(itype(LW, 5'd12), 32'h0030, 32'd0, 32'd0, 1'b0, 1'b0);
        check("fwd_load", {27'd0, fwd_m_addr}, 32'd0);
        tick();

        drive(itype(6'b000011, 5'd0), 32'h0000_0777, 32'd0, 32'h3008, 1'b0, 1'b0);
        check("fwd_jal_addr", {27'd0, fwd_m_addr}, 32'd31);
        check("fwd_jal_data", fwd_m_data, 32'h3008);
        tick();
        check("jal_we", {31'd0, rf_we_w}, 32'd1);
        check("jal_waddr", {27'd0, rf_waddr_w}, 32'd31);
        check("jal_data", rf_wdata_w, 32'h3008);

        drive({6'b000001, 5'd0, 5'b10001, 16'd0}, 32'd0, 32'd0, 32'h4008, 1'b0, 1'b0);
        check("fwd_bgezal0", {27'd0, fwd_m_addr}, 32'd0);
        tick();
        check("bgezal0_we", {31'd0, rf_we_w}, 32'd0);
        drive({6'b000001, 5'd0, 5'b10001, 16'd0}, 32'd0, 32'd0, 32'h4008, 1'b1, 1'b0);
        tick();
        check("bgezal1_waddr", {27'd0, rf_waddr_w}, 32'd31);
        check("bgezal1_data", rf_wdata_w, 32'h4008);

        drive(rtype(6'b001010, 5'd5), 32'hDEAD0001, 32'd0, 32'd0, 1'b0, 1'b0);
        check("fwd_movz0", {27'd0, fwd_m_addr}, 32'd0);
        tick();
        check("movz0_we", {31'd0, rf_we_w}, 32'd0);
        drive(rtype(6'b001010, 5'd5), 32'hDEAD0001, 32'd0, 32'd0, 1'b0, 1'b1);
        check("fwd_movz1", {27'd0, fwd_m_addr}, 32'd5);
        tick();
        check("movz1_waddr", {27'd0, rf_waddr_w}, 32'd5);
        check("movz1_data", rf_wdata_w, 32'hDEAD0001);

        drive(rtype(6'b100001, 5'd3), 32'h0000_0055, 32'd0, 32'h9999, 1'b0, 1'b0);
        check("fwd_addu_addr", {27'd0, fwd_m_addr}, 32'd3);
        check("fwd_addu_data", fwd_m_data, 32'h55);
        tick();
        drive(rtype(6'b001001, 5'd4), 32'h0000_0123, 32'd0, 32'h5008, 1'b0, 1'b0);
        check("fwd_jalr_data", fwd_m_data, 32'h5008);
        tick();
        check("jalr_data", rf_wdata_w, 32'h5008);

        step({6'b000100, 26'h0}, 32'h0000_0042, 32'd0);
        check("beq_we", {31'd0, rf_we_w}, 32'd0);

        step(itype(SW, 5'd1), 32'h0000_1010, 32'hCAFEF00D);
        step(itype(LW, 5'd13), 32'h0000_0010, 32'd0);
        check("wrap_lw", rf_wdata_w, 32'hCAFEF00D);

        drive(itype(6'b001101, 5'd0), 32'h0000_FFFF, 32'd0, 32'd0, 1'b0, 1'b0);
        check("fwd_ori0", {27'd0, fwd_m_addr}, 32'd0);
        tick();
        check("ori0_we", {31'd0, rf_we_w}, 32'd0);
        check("ori0_waddr", {27'd0, rf_waddr_w}, 32'd0);
        check("ori0_data", rf_wdata_w, 32'd0);

        step(itype(6'b001101, 5'd6), 32'h0000_ABCD, 32'd0);
        check("ori6_data", rf_wdata_w, 32'h0000ABCD);

        reset = 1'b1;
        step(itype(SW, 5'd1), 32'h0040, 32'h11111111);
        check("mid_rst_ir", ir_w, 32'd0);
        check("mid_rst_we", {31'd0, rf_we_w}, 32'd0);
        check("mid_rst_waddr", {27'd0, rf_waddr_w}, 32'd0);
        check("mid_rst_data", rf_wdata_w, 32'd0);
        reset = 1'b0;
        step(itype(LW, 5'd14), 32'h0040, 32'd0);
        check("rst_drop_sw", rf_wdata_w, 32'd0);
        step(itype(LW, 5'd14), 32'h0030, 32'd0);
        check("rst_clr30", rf_wdata_w, 32'd0);
        step(itype(LW, 5'd14), 32'h0010, 32'd0);
        check("rst_clr10", rf_wdata_w, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
